// File: rtl/interp_phase_sched.sv
// rtl/interp_phase_sched.sv - sequencing controller for a polyphase interpolator
//
// Accepts one sample from the source and waits FILTER_LAT cycles for the branch
// FIR outputs. It then pulses en_out so the shared branch output registers
// load, and emits L phases (L = 2, 4 or 8) to the sink. All outputs are forced
// to 0 while arst_n is low.
//
// Optional build macro: INTERP_SCHED_UNDERRUN_CNT_EN adds underrun_cnt_out.
//
// Ports:
//   clk              system clock
//   arst_n           synchronous active-low reset
//   rate_sel[1:0]    interpolation factor: 0=2, 1=4, 2=8, 3=reserved (treated as 2)
//   bypass           pass-through request, honoured only while idle
//   src_valid_in     upstream sample valid
//   src_ready_out    scheduler can accept a sample
//   dst_valid_out    current phase output valid
//   dst_ready_in     downstream ready
//   en_out           one-cycle load enable for the branch output registers
//   phase_out        branch select for the output mux
//   busy_out         high whenever the FSM is not idle
//   rate_err_out     pulses when a sample is accepted with rate_sel=3
//   underrun_cnt_out saturating count of sink-ready cycles with no valid output (optional)

module interp_phase_sched #(
    parameter int MAX_RATE   = 8,
    parameter int FILTER_LAT = 1,
    localparam int PHASE_W   = $clog2(MAX_RATE)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [1:0]         rate_sel,
    input  logic               bypass,
    input  logic               src_valid_in,
    output logic               src_ready_out,
    output logic               dst_valid_out,
    input  logic               dst_ready_in,
    output logic               en_out,
    output logic [PHASE_W-1:0] phase_out,
    output logic               busy_out,
    output logic               rate_err_out
`ifdef INTERP_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]        underrun_cnt_out
`endif
);

    localparam int CNT_W = (FILTER_LAT > 1) ? $clog2(FILTER_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_last_phase;

    logic               w_accept;
    logic               w_byp_active;
    logic               w_src_ready;
    logic               w_dst_valid;
    logic               w_en;
    logic [PHASE_W-1:0] w_phase;
    logic [PHASE_W-1:0] w_sel_last;

    // Last phase index (L-1) for a rate_sel code; the reserved code falls back to
    // rate 2, and rates above MAX_RATE clamp to MAX_RATE.
    function automatic logic [PHASE_W-1:0] last_phase_of(input logic [1:0] sel);
        int rate;
        case (sel)
            2'd1:    rate = 4;
            2'd2:    rate = 8;
            default: rate = 2;
        endcase
        if (rate > MAX_RATE) begin
            rate = MAX_RATE;
        end
        return PHASE_W'(rate - 1);
    endfunction

    assign w_sel_last = last_phase_of(rate_sel);

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_byp_active = 1'b0;
        w_src_ready  = 1'b0;
        w_dst_valid  = 1'b0;
        w_en         = 1'b0;
        w_phase      = '0;
        case (r_state)
            S_IDLE: begin
                if (bypass) begin
                    // Pass-through: the FSM never leaves idle and the filter is not loaded.
                    w_byp_active = 1'b1;
                    w_src_ready  = dst_ready_in;
                    w_dst_valid  = src_valid_in;
                end else begin
                    w_src_ready = 1'b1;
                    if (src_valid_in) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_en        = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_dst_valid = 1'b1;
                w_phase     = r_phase;
                if (dst_ready_in && (r_phase == r_last_phase)) begin
                    // Final phase handshake frees the slot in the same cycle,
                    // allowing a back-to-back accept.
                    w_src_ready = 1'b1;
                    if (src_valid_in) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_phase      <= '0;
            r_last_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt        <= CNT_LOAD;
                r_last_phase <= w_sel_last;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt == '0) begin
                    r_phase <= '0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
            if ((r_state == S_EMIT) && dst_ready_in && (r_phase != r_last_phase)) begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign src_ready_out = arst_n & w_src_ready;
    assign dst_valid_out = arst_n & w_dst_valid;
    assign en_out        = arst_n & w_en;
    assign phase_out     = arst_n ? w_phase : '0;
    assign busy_out      = arst_n & (r_state != S_IDLE);
    assign rate_err_out  = arst_n & w_accept & (rate_sel == 2'd3);

`ifdef INTERP_SCHED_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_underrun_cnt <= '0;
        end else if (dst_ready_in && !w_dst_valid && !w_byp_active
                     && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt_out = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_interp_phase_sched.sv
// tb/tb_interp_phase_sched.sv - directed self-checking bench for interp_phase_sched

module tb_interp_phase_sched;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       bypass = 1'b0;
    logic       src_valid_in = 1'b0;
    logic       src_ready_out;
    logic       dst_valid_out;
    logic       dst_ready_in = 1'b0;
    logic       en_out;
    logic [2:0] phase_out;
    logic       busy_out;
    logic       rate_err_out;
`ifdef INTERP_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    interp_phase_sched #(.MAX_RATE(8), .FILTER_LAT(1)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .rate_sel      (rate_sel),
        .bypass        (bypass),
        .src_valid_in  (src_valid_in),
        .src_ready_out (src_ready_out),
        .dst_valid_out (dst_valid_out),
        .dst_ready_in  (dst_ready_in),
        .en_out        (en_out),
        .phase_out     (phase_out),
        .busy_out      (busy_out),
        .rate_err_out  (rate_err_out)
`ifdef INTERP_SCHED_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_out (underrun_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the WAIT cycle after an accept; drives the sink and checks each
    // handshake phase, stalling stall_len cycles when stall_ph is presented.
    task automatic run_emit(input int rate, input int stall_ph, input int stall_len);
        int hs = 0;
        int ens = 0;
        int stalled = 0;
        for (int c = 0; c < 60 && hs < rate; c++) begin
            dst_ready_in = !(dst_valid_out && (int'(phase_out) == stall_ph) && (stalled < stall_len));
            #1;
            if (en_out) ens++;
            if (dst_valid_out && !dst_ready_in) begin
                check("stall_phase_hold", phase_out, stall_ph);
                check("stall_valid_hold", dst_valid_out, 1);
                stalled++;
            end
            if (dst_valid_out && dst_ready_in) begin
                check("emit_phase", phase_out, hs);
                hs++;
            end
            tick();
        end
        check("emit_hs_count", hs, rate);
        check("emit_en_count", ens, 1);
        check("emit_stall_count", stalled, stall_len);
        dst_ready_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] acc_mask;
        logic [11:0] en_mask;
        logic [31:0] hs_ph;
        int          nh;
        int          drain_hs;

        // Reset: every output held at 0 while arst_n is low.
        tick();
        tick();
        #1;
        check("rst_src_ready", src_ready_out, 0);
        check("rst_dst_valid", dst_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_en", en_out, 0);
        arst_n = 1'b1;
        #1;
        check("idle_src_ready", src_ready_out, 1);

        // Rate 2, FILTER_LAT=1.
        rate_sel = 2'd0; src_valid_in = 1'b1; dst_ready_in = 1'b1;
        #1;
        check("r2_accept_ready", src_ready_out, 1);
        tick();
        src_valid_in = 1'b0;
        #1;
        check("r2_en_c1", en_out, 1);
        check("r2_busy_c1", busy_out, 1);
        check("r2_ready_c1", src_ready_out, 0);
        tick(); #1;
        check("r2_valid_c2", dst_valid_out, 1);
        check("r2_phase_c2", phase_out, 0);
        check("r2_ready_c2", src_ready_out, 0);
        tick(); #1;
        check("r2_phase_c3", phase_out, 1);
        check("r2_ready_c3", src_ready_out, 1);
        tick(); #1;
        check("r2_idle_busy", busy_out, 0);
        check("r2_idle_valid", dst_valid_out, 0);

        // Rate 8 with a 3-cycle sink stall at phase 5.
        rate_sel = 2'd2; src_valid_in = 1'b1;
        #1;
        tick();
        src_valid_in = 1'b0;
        run_emit(8, 5, 3);
        #1;
        check("r8_done_busy", busy_out, 0);

        // Back-to-back at rate 4, rate_sel switched to code 0 mid-emit.
        acc_mask = '0; en_mask = '0; hs_ph = '0; nh = 0;
        for (int c = 0; c < 12; c++) begin
            rate_sel = (c >= 2) ? 2'd0 : 2'd1;
            src_valid_in = 1'b1; dst_ready_in = 1'b1;
            #1;
            if (src_valid_in && src_ready_out) acc_mask[c] = 1'b1;
            if (en_out) en_mask[c] = 1'b1;
            if (dst_valid_out && dst_ready_in && nh < 8) begin
                hs_ph[nh*4 +: 4] = {1'b0, phase_out};
                nh++;
            end
            tick();
        end
        src_valid_in = 1'b0;
        check("b2b_accepts", acc_mask, 12'h921);
        check("b2b_en", en_mask, 12'h242);
        check("b2b_hs_n", nh, 8);
        check("b2b_phases", hs_ph, 32'h1010_3210);
        drain_hs = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!busy_out) break;
            if (dst_valid_out && dst_ready_in) drain_hs++;
            tick();
        end
        check("b2b_drain_hs", drain_hs, 2);
        check("b2b_drain_idle", busy_out, 0);

        // Reserved rate code: error pulse and two phases.
        rate_sel = 2'd3; src_valid_in = 1'b1;
        #1;
        check("rerr_pulse", rate_err_out, 1);
        tick();
        src_valid_in = 1'b0;
        #1;
        check("rerr_clear", rate_err_out, 0);
        run_emit(2, 99, 0);

        // Reset while emitting phase 2 of a rate-8 sample.
        rate_sel = 2'd2; src_valid_in = 1'b1;
        #1;
        tick();
        src_valid_in = 1'b0;
        tick(); tick(); tick();
        #1;
        check("rstm_phase2", phase_out, 2);
        arst_n = 1'b0;
        tick(); #1;
        check("rstm_src_ready", src_ready_out, 0);
        check("rstm_dst_valid", dst_valid_out, 0);
        check("rstm_en", en_out, 0);
        check("rstm_phase", phase_out, 0);
        check("rstm_busy", busy_out, 0);
        arst_n = 1'b1;
        #1;
        check("rstm_rel_ready", src_ready_out, 1);
        tick(); #1;
        check("rstm_rel_busy", busy_out, 0);
        check("rstm_rel_valid", dst_valid_out, 0);

        // Bypass in idle with the sink not ready.
        bypass = 1'b1; dst_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_valid_in = i[0];
            #1;
            check("byp_src_ready", src_ready_out, 0);
            check("byp_dst_valid", dst_valid_out, i & 1);
            check("byp_en", en_out, 0);
            tick();
        end
        dst_ready_in = 1'b1; src_valid_in = 1'b1;
        #1;
        check("byp_ready_follow", src_ready_out, 1);
        tick(); #1;
        check("byp_stays_idle", busy_out, 0);
        bypass = 1'b0; src_valid_in = 1'b0; dst_ready_in = 1'b0;

`ifdef INTERP_SCHED_UNDERRUN_CNT_EN
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        tick(); #1;
        check("urun_after_rst", underrun_cnt_out, 0);
        dst_ready_in = 1'b1;
        tick(); tick(); tick();
        #1;
        check("urun_count3", underrun_cnt_out, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
